// File: rtl/range_list_parser.sv
// ASCII "lo-hi,lo-hi,..." stream parser: emits one (lo, hi) pair per handshake,
// flags malformed input, overflow and inverted ranges, then halts until reset.
module range_list_parser #(
    parameter int unsigned VALUE_W = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VALUE_W-1:0] out_lo,
    output logic [VALUE_W-1:0] out_hi,
    output logic [CNT_W-1:0]   range_count,
    output logic               done,
    output logic               error,
    output logic [2:0]         err_code
);

    typedef enum logic [2:0] {
        S_LO_FIRST, S_LO_DIGITS, S_HI_FIRST, S_HI_DIGITS,
        S_EMIT, S_TAIL, S_DONE, S_ERR
    } state_t;

    state_t               state_q, state_d, pend_q, pend_d;
    logic [VALUE_W-1:0]   acc_q, acc_d, lo_q, lo_d;
    logic [VALUE_W-1:0]   out_lo_q, out_lo_d, out_hi_q, out_hi_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           err_q, err_d;

    logic                 accept, is_digit, is_ws, is_comma, is_dash, ovf;
    logic [3:0]           dval;
    logic [VALUE_W+3:0]   acc_new;
    logic                 term, fault;
    logic [VALUE_W-1:0]   term_hi, dval_ext;
    state_t               term_next;
    logic [2:0]           fault_code;

    assign in_ready = !rst && (state_q inside {S_LO_FIRST, S_LO_DIGITS, S_HI_FIRST,
                                               S_HI_DIGITS, S_TAIL});
    assign accept   = in_valid && in_ready;
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_ws    = (in_data == 8'h20) || (in_data == 8'h0D) || (in_data == 8'h0A);
    assign is_comma = (in_data == 8'h2C);
    assign is_dash  = (in_data == 8'h2D);
    assign dval     = in_data[3:0];
    assign dval_ext = {{(VALUE_W-4){1'b0}}, dval};
    // Four guard bits catch any acc*10+d that exceeds VALUE_W bits.
    assign acc_new  = {4'b0000, acc_q} * (VALUE_W+4)'(10) + (VALUE_W+4)'(dval);
    assign ovf      = |acc_new[VALUE_W+3:VALUE_W];

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        out_lo_d   = out_lo_q;
        out_hi_d   = out_hi_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        term       = 1'b0;
        term_hi    = acc_q;
        term_next  = S_LO_FIRST;
        fault      = 1'b0;
        fault_code = 3'd0;

        if (accept) begin
            unique case (state_q)
                S_LO_FIRST: begin
                    if (is_digit) begin
                        if (in_last) begin fault = 1'b1; fault_code = 3'd4; end
                        else begin acc_d = dval_ext; state_d = S_LO_DIGITS; end
                    end else if (is_ws) begin
                        if (in_last) begin fault = 1'b1; fault_code = 3'd4; end
                    end else begin fault = 1'b1; fault_code = 3'd1; end
                end
                S_LO_DIGITS: begin
                    if (is_digit) begin
                        if (ovf)          begin fault = 1'b1; fault_code = 3'd2; end
                        else if (in_last) begin fault = 1'b1; fault_code = 3'd4; end
                        else acc_d = acc_new[VALUE_W-1:0];
                    end else if (is_dash) begin
                        if (in_last) begin fault = 1'b1; fault_code = 3'd4; end
                        else begin lo_d = acc_q; acc_d = '0; state_d = S_HI_FIRST; end
                    end else begin fault = 1'b1; fault_code = 3'd1; end
                end
                S_HI_FIRST: begin
                    if (is_digit) begin
                        if (in_last) begin term = 1'b1; term_hi = dval_ext; term_next = S_DONE; end
                        else begin acc_d = dval_ext; state_d = S_HI_DIGITS; end
                    end else begin fault = 1'b1; fault_code = 3'd1; end
                end
                S_HI_DIGITS: begin
                    if (is_digit) begin
                        if (ovf) begin fault = 1'b1; fault_code = 3'd2; end
                        else if (in_last) begin
                            term = 1'b1; term_hi = acc_new[VALUE_W-1:0]; term_next = S_DONE;
                        end else acc_d = acc_new[VALUE_W-1:0];
                    end else if (is_comma) begin
                        if (in_last) begin fault = 1'b1; fault_code = 3'd4; end
                        else begin term = 1'b1; term_next = S_LO_FIRST; end
                    end else if (is_ws) begin
                        term = 1'b1;
                        term_next = in_last ? S_DONE : S_TAIL;
                    end else begin fault = 1'b1; fault_code = 3'd1; end
                end
                S_TAIL: begin
                    if (is_ws) begin
                        if (in_last) state_d = S_DONE;
                    end else if (is_comma) begin
                        if (in_last) begin fault = 1'b1; fault_code = 3'd4; end
                        else state_d = S_LO_FIRST;
                    end else begin fault = 1'b1; fault_code = 3'd1; end
                end
                default: ;
            endcase
        end

        if (state_q == S_EMIT && out_ready) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = pend_q;
        end

        if (term) begin
            if (lo_q > term_hi) begin
                fault = 1'b1; fault_code = 3'd3;
            end else begin
                out_lo_d = lo_q;
                out_hi_d = term_hi;
                pend_d   = term_next;
                acc_d    = '0;
                state_d  = S_EMIT;
            end
        end

        if (fault) begin
            state_d = S_ERR;
            err_d   = fault_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LO_FIRST;
            pend_q   <= S_LO_FIRST;
            acc_q    <= '0;
            lo_q     <= '0;
            out_lo_q <= '0;
            out_hi_q <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            out_lo_q <= out_lo_d;
            out_hi_q <= out_hi_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign out_valid   = (state_q == S_EMIT);
    assign out_lo      = out_lo_q;
    assign out_hi      = out_hi_q;
    assign range_count = cnt_q;
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERR);
    assign err_code    = err_q;

endmodule

// File: tb/tb_range_list_parser.sv
// Bench for range_list_parser: directed stream scenarios plus random streams
// checked against a token-level reference parser.
module tb_range_list_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_lo, out_hi;
    logic [15:0] range_count;
    logic        done, error;
    logic [2:0]  err_code;

    range_list_parser #(.VALUE_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_lo(out_lo), .out_hi(out_hi),
        .range_count(range_count), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    localparam longint unsigned MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned    s[$];
    longint unsigned got_lo[$], got_hi[$], exp_lo[$], exp_hi[$];
    int              accepted;
    bit              saw_valid;
    int              exp_code, exp_used;

    function automatic bit is_ws(byte unsigned c);
        return c == 8'h20 || c == 8'h0D || c == 8'h0A;
    endfunction

    function automatic bit is_dig(byte unsigned c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    task automatic load_str(input string str);
        s.delete();
        for (int i = 0; i < str.len(); i++) s.push_back(str[i]);
    endtask

    task automatic push_dec(input longint unsigned v);
        byte unsigned t[$];
        if (v == 0) t.push_back(8'h30);
        while (v != 0) begin
            t.push_front(8'h30 + byte'(v % 10));
            v = v / 10;
        end
        foreach (t[k]) s.push_back(t[k]);
    endtask

    // Token-level reference: walks the string as "ws* num '-' num (sep ...)".
    // exp_code 0 means clean completion; exp_used is bytes consumed.
    task automatic model_run();
        int i = 0;
        int n = s.size();
        int code = 0;
        bit fin = 0;
        bit term;
        longint unsigned v, lo, d;
        exp_lo.delete(); exp_hi.delete();
        while (!fin && code == 0) begin
            while (is_ws(s[i]) && code == 0) begin
                if (i == n - 1) code = 4; else i++;
            end
            if (code != 0) break;
            if (!is_dig(s[i])) begin code = 1; break; end
            v = 0;
            while (is_dig(s[i]) && code == 0) begin
                d = longint'(s[i] - 8'h30);
                if (v > (MAX64 - d) / 10) code = 2;
                else begin
                    v = v * 10 + d;
                    if (i == n - 1) code = 4; else i++;
                end
            end
            if (code != 0) break;
            if (s[i] != 8'h2D) begin code = 1; break; end
            if (i == n - 1) begin code = 4; break; end
            i++;
            lo = v;
            if (!is_dig(s[i])) begin code = 1; break; end
            v = 0; term = 0;
            while (is_dig(s[i]) && code == 0 && !term) begin
                d = longint'(s[i] - 8'h30);
                if (v > (MAX64 - d) / 10) code = 2;
                else begin
                    v = v * 10 + d;
                    if (i == n - 1) term = 1; else i++;
                end
            end
            if (code != 0) break;
            if (term) begin
                if (lo > v) code = 3;
                else begin exp_lo.push_back(lo); exp_hi.push_back(v); fin = 1; end
                break;
            end
            if (s[i] == 8'h2C) begin
                if (i == n - 1) begin code = 4; break; end
                if (lo > v) begin code = 3; break; end
                exp_lo.push_back(lo); exp_hi.push_back(v);
                i++;
                continue;
            end
            if (!is_ws(s[i])) begin code = 1; break; end
            if (lo > v) begin code = 3; break; end
            exp_lo.push_back(lo); exp_hi.push_back(v);
            if (i == n - 1) begin fin = 1; break; end
            i++;
            while (is_ws(s[i]) && !fin) begin
                if (i == n - 1) fin = 1; else i++;
            end
            if (fin) break;
            if (s[i] != 8'h2C) begin code = 1; break; end
            if (i == n - 1) begin code = 4; break; end
            i++;
        end
        exp_code = code;
        exp_used = i + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Drives s[] into the DUT and collects handshaken pairs.
    // mode 0: out_ready high; 1: random; 2: 5-cycle stall on first pair.
    task automatic run_stream(input int mode, input bit gaps, input bit last_en);
        int idx = 0, cyc = 0, stall = 0, acc_cyc = -10, hs_cyc = -10;
        bit seen_first = 0, prev_hold = 0, end_seen = 0;
        longint unsigned hl = 0, hh = 0;
        got_lo.delete(); got_hi.delete(); saw_valid = 0;
        while (cyc < 3000) begin
            @(posedge clk); #1; cyc++;
            if (prev_hold) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_lo !== hl || out_hi !== hh) begin
                    n_bad++;
                    $display("FAIL hold: valid=%b lo=%0d hi=%0d expected valid=1 lo=%0d hi=%0d",
                             out_valid, out_lo, out_hi, hl, hh);
                end
            end
            if (out_valid) begin
                saw_valid = 1;
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL emit_ready: in_ready=%b expected 0", in_ready);
                end
            end
            if (error) begin
                n_cmp++;
                if (cyc != acc_cyc + 1) begin
                    n_bad++;
                    $display("FAIL err_latency: error at cycle %0d expected %0d", cyc, acc_cyc + 1);
                end
                end_seen = 1;
                break;
            end
            if (done) begin
                n_cmp++;
                if (cyc != ((acc_cyc > hs_cyc) ? acc_cyc : hs_cyc) + 1) begin
                    n_bad++;
                    $display("FAIL done_latency: done at cycle %0d expected %0d", cyc,
                             ((acc_cyc > hs_cyc) ? acc_cyc : hs_cyc) + 1);
                end
                end_seen = 1;
                break;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (out_valid && !seen_first) begin seen_first = 1; stall = 5; end
                    if (stall > 0) begin out_ready = 1'b0; stall--; end
                    else out_ready = 1'b1;
                end
            endcase
            prev_hold = out_valid && !out_ready;
            hl = out_lo; hh = out_hi;
            if (out_valid && out_ready) begin
                got_lo.push_back(out_lo); got_hi.push_back(out_hi); hs_cyc = cyc;
            end
            if (in_ready && idx < s.size() && !(gaps && $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b1; in_data = s[idx];
                in_last = last_en && (idx == s.size() - 1);
                idx++; acc_cyc = cyc;
            end else begin
                in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        accepted = idx;
        n_cmp++;
        if (!end_seen) begin
            n_bad++;
            $display("FAIL timeout: neither done nor error within cycle budget");
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || (done | error) !== 1'b1) begin
            n_bad++;
            $display("FAIL terminal: in_ready=%b out_valid=%b done=%b error=%b expected 0 0 and done|error",
                     in_ready, out_valid, done, error);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_lo !== 64'd0 || out_hi !== 64'd0 ||
            range_count !== 16'd0 || done !== 1'b0 || error !== 1'b0 || err_code !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_vals: rdy=%b v=%b lo=%0d hi=%0d cnt=%0d done=%b err=%b code=%0d expected all 0",
                     in_ready, out_valid, out_lo, out_hi, range_count, done, error, err_code);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_basic(input int mode);
        do_reset();
        load_str("11-22,95-115\n");
        run_stream(mode, 0, 1);
        n_cmp++;
        if (got_lo.size() != 2 || got_lo[0] != 11 || got_hi[0] != 22 ||
            got_lo[1] != 95 || got_hi[1] != 115) begin
            n_bad++;
            $display("FAIL basic_pairs(mode %0d): got %0d pairs lo0=%0d hi0=%0d expected (11,22),(95,115)",
                     mode, got_lo.size(), (got_lo.size() > 0) ? got_lo[0] : 0,
                     (got_hi.size() > 0) ? got_hi[0] : 0);
        end
        n_cmp++;
        if (range_count !== 16'd2 || done !== 1'b1 || error !== 1'b0 || accepted != 13) begin
            n_bad++;
            $display("FAIL basic_final(mode %0d): cnt=%0d done=%b err=%b used=%0d expected 2 1 0 13",
                     mode, range_count, done, error, accepted);
        end
    endtask

    task automatic test_max_and_overflow();
        do_reset();
        load_str("18446744073709551615-18446744073709551615");
        run_stream(0, 1, 1);
        n_cmp++;
        if (got_lo.size() != 1 || got_lo[0] != MAX64 || got_hi[0] != MAX64 ||
            done !== 1'b1 || range_count !== 16'd1) begin
            n_bad++;
            $display("FAIL max_value: pairs=%0d done=%b cnt=%0d expected one (2^64-1,2^64-1), done=1",
                     got_lo.size(), done, range_count);
        end
        do_reset();
        load_str("18446744073709551616-1");
        run_stream(0, 0, 1);
        n_cmp++;
        if (error !== 1'b1 || err_code !== 3'd2 || accepted != 20 || saw_valid) begin
            n_bad++;
            $display("FAIL overflow: err=%b code=%0d used=%0d saw_valid=%b expected 1 2 20 0",
                     error, err_code, accepted, saw_valid);
        end
    endtask

    task automatic test_errors();
        do_reset();
        load_str("50-40,");
        run_stream(0, 0, 0);
        n_cmp++;
        if (error !== 1'b1 || err_code !== 3'd3 || accepted != 6 || saw_valid) begin
            n_bad++;
            $display("FAIL inverted: err=%b code=%0d used=%0d saw_valid=%b expected 1 3 6 0",
                     error, err_code, accepted, saw_valid);
        end
        do_reset();
        load_str("12a-3");
        run_stream(0, 0, 1);
        n_cmp++;
        if (error !== 1'b1 || err_code !== 3'd1 || accepted != 3) begin
            n_bad++;
            $display("FAIL bad_char: err=%b code=%0d used=%0d expected 1 1 3", error, err_code, accepted);
        end
        do_reset();
        load_str("1-2,");
        run_stream(0, 0, 1);
        n_cmp++;
        if (error !== 1'b1 || err_code !== 3'd4 || range_count !== 16'd0 || saw_valid) begin
            n_bad++;
            $display("FAIL trailing_comma: err=%b code=%0d cnt=%0d saw_valid=%b expected 1 4 0 0",
                     error, err_code, range_count, saw_valid);
        end
    endtask

    task automatic test_reset_mid_emit();
        string str = "1-2,";
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = str[i]; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_lo !== 64'd1 || out_hi !== 64'd2) begin
            n_bad++;
            $display("FAIL emit_latency: v=%b lo=%0d hi=%0d expected 1 1 2", out_valid, out_lo, out_hi);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || range_count !== 16'd0 || in_ready !== 1'b0 || out_lo !== 64'd0) begin
            n_bad++;
            $display("FAIL rst_mid_emit: v=%b cnt=%0d rdy=%b lo=%0d expected 0 0 0 0",
                     out_valid, range_count, in_ready, out_lo);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        load_str("7-9");
        run_stream(0, 0, 1);
        n_cmp++;
        if (got_lo.size() != 1 || got_lo[0] != 7 || got_hi[0] != 9 || done !== 1'b1 ||
            range_count !== 16'd1) begin
            n_bad++;
            $display("FAIL after_reset: pairs=%0d done=%b cnt=%0d expected (7,9) done=1 cnt=1",
                     got_lo.size(), done, range_count);
        end
    endtask

    function automatic longint unsigned rand_val();
        case ($urandom_range(0, 3))
            0: return longint'($urandom_range(0, 999));
            1: return longint'($urandom);
            2: return {$urandom, $urandom};
            default: return MAX64 - longint'($urandom_range(0, 20));
        endcase
    endfunction

    task automatic gen_random();
        string pool = "0123456789-, \n\rx:";
        int np = $urandom_range(1, 4);
        longint unsigned lo, hi, t;
        s.delete();
        if ($urandom_range(0, 3) == 0) s.push_back(8'h20);
        for (int p = 0; p < np; p++) begin
            lo = rand_val(); hi = rand_val();
            if (lo > hi && $urandom_range(0, 9) != 0) begin t = lo; lo = hi; hi = t; end
            if ($urandom_range(0, 5) == 0) s.push_back(8'h30);
            push_dec(lo);
            s.push_back(8'h2D);
            push_dec(hi);
            if ($urandom_range(0, 7) == 0) s.push_back(8'h37);
            if (p < np - 1) begin
                case ($urandom_range(0, 2))
                    0: s.push_back(8'h2C);
                    1: begin s.push_back(8'h20); s.push_back(8'h2C); end
                    default: begin s.push_back(8'h0D); s.push_back(8'h0A); s.push_back(8'h2C); end
                endcase
            end
        end
        case ($urandom_range(0, 3))
            0: ;
            1: s.push_back(8'h0A);
            2: begin s.push_back(8'h20); s.push_back(8'h0D); s.push_back(8'h0A); end
            default: s.push_back(8'h2C);
        endcase
        if ($urandom_range(0, 3) == 0)
            s[$urandom_range(0, s.size() - 1)] = pool[$urandom_range(0, pool.len() - 1)];
    endtask

    task automatic test_random(input int count);
        bit pairs_ok;
        for (int k = 0; k < count; k++) begin
            gen_random();
            model_run();
            do_reset();
            run_stream(1, 1, 1);
            pairs_ok = (got_lo.size() == exp_lo.size());
            if (pairs_ok)
                foreach (exp_lo[j])
                    if (got_lo[j] != exp_lo[j] || got_hi[j] != exp_hi[j]) pairs_ok = 0;
            n_cmp++;
            if (!pairs_ok) begin
                n_bad++;
                $display("FAIL rand_pairs[%0d]: got %0d pairs expected %0d (or values differ)",
                         k, got_lo.size(), exp_lo.size());
            end
            n_cmp++;
            if (range_count !== 16'(exp_lo.size())) begin
                n_bad++;
                $display("FAIL rand_count[%0d]: range_count=%0d expected %0d", k, range_count, exp_lo.size());
            end
            n_cmp++;
            if (done !== (exp_code == 0) || error !== (exp_code != 0) || err_code !== 3'(exp_code)) begin
                n_bad++;
                $display("FAIL rand_status[%0d]: done=%b err=%b code=%0d expected code %0d",
                         k, done, error, err_code, exp_code);
            end
            n_cmp++;
            if (accepted != exp_used) begin
                n_bad++;
                $display("FAIL rand_used[%0d]: bytes accepted=%0d expected %0d", k, accepted, exp_used);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_basic(2);
        test_max_and_overflow();
        test_errors();
        test_reset_mid_emit();
        test_random(60);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
